// File: rtl/line_memory.sv
// Cache-line memory model: one 256-bit line request at a time, completed after LATENCY cycles.
// Optional read/write completion counters enabled by defining LINE_MEM_STATS_EN.
module line_memory #(
    parameter int LATENCY = 10,
    parameter int DEPTH   = 512
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         enable_i,
    input  logic         write_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    output logic         ack_o,
    output logic [255:0] data_o,
    output logic         busy_o
`ifdef LINE_MEM_STATS_EN
    ,
    output logic [15:0]  rd_count_o,
    output logic [15:0]  wr_count_o
`endif
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [7:0] LAST = 8'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t             state;
    logic [7:0]         cnt;
    logic [IDX_W-1:0]   idx;
    logic               wr;
    logic [255:0]       wdata;
    logic [255:0]       mem [DEPTH];
    logic               done;

    // Offset bits and bits above the line index are deliberately ignored (address wrap).
    logic unused_addr;
    assign unused_addr = ^{addr_i[31:5+IDX_W], addr_i[4:0]};

    assign done = (state == BUSY) && (cnt == LAST);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            wr     <= 1'b0;
            wdata  <= '0;
            ack_o  <= 1'b0;
            busy_o <= 1'b0;
            data_o <= '0;
`ifdef LINE_MEM_STATS_EN
            rd_count_o <= '0;
            wr_count_o <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (enable_i) begin
                        idx    <= addr_i[4+IDX_W:5];
                        wr     <= write_i;
                        wdata  <= data_i;
                        cnt    <= '0;
                        busy_o <= 1'b1;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == LAST) begin
                        state <= ACK;
                        ack_o <= 1'b1;
                        if (!wr) data_o <= mem[idx];
`ifdef LINE_MEM_STATS_EN
                        if (wr) begin
                            if (wr_count_o != 16'hFFFF) wr_count_o <= wr_count_o + 16'd1;
                        end else begin
                            if (rd_count_o != 16'hFFFF) rd_count_o <= rd_count_o + 16'd1;
                        end
`endif
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ACK: begin
                    ack_o  <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Array has no reset; reset forces IDLE so a pending write never reaches here.
    always_ff @(posedge clk_i) begin
        if (done && wr) mem[idx] <= wdata;
    end

endmodule
